// File: rtl/lpc_cycle_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : lpc_cycle_decoder
//  Purpose  : Passive LPC bus cycle decoder. Follows the sniffed LPC pins and
//             decodes I/O read/write and (optionally) memory read/write
//             cycles, including wait-state SYNCs, ABORT and SYNC timeout.
//             Emits one captured-cycle record per completed cycle. Never
//             drives the bus.
//  Ports    : lpc_clock        in   LPC clock (only clock)
//             reset            in   synchronous active-high reset
//             lpc_ad[3:0]      in   LAD[3:0]
//             lpc_frame        in   LFRAME#, active low
//             out_cyctype_dir  out  cycle type/direction nibble
//             out_addr[31:0]   out  address (upper 16 bits zero for I/O)
//             out_data[7:0]    out  data byte
//             out_sync_error   out  record completed with error SYNC
//             out_valid        out  one-clock pulse: record fields valid
//             out_sync_timeout out  one-clock pulse: SYNC wait timed out
//             out_abort        out  one-clock pulse: ABORT in active cycle
//  Revision : 1.0  initial release
// ============================================================================
module lpc_cycle_decoder #(
    parameter bit          ENABLE_IO_WRITE = 1'b1,
    parameter bit          ENABLE_MEM      = 1'b0,
    parameter int          SYNC_TIMEOUT    = 16,
    parameter logic [31:0] ADDR_MASK       = 32'h0000_0000,
    parameter logic [31:0] ADDR_MATCH      = 32'h0000_0000
) (
    input  logic        lpc_clock,
    input  logic        reset,
    input  logic [3:0]  lpc_ad,
    input  logic        lpc_frame,
    output logic [3:0]  out_cyctype_dir,
    output logic [31:0] out_addr,
    output logic [7:0]  out_data,
    output logic        out_sync_error,
    output logic        out_valid,
    output logic        out_sync_timeout,
    output logic        out_abort
);

    localparam int CW = $clog2(SYNC_TIMEOUT + 1);
    localparam logic [CW:0] c_TIMEOUT = (CW + 1)'(SYNC_TIMEOUT);

    localparam logic [3:0] c_IDLE   = 4'd0;
    localparam logic [3:0] c_CYCDIR = 4'd1;
    localparam logic [3:0] c_ADDR   = 4'd2;
    localparam logic [3:0] c_WDATA  = 4'd3;
    localparam logic [3:0] c_TAR1   = 4'd4;
    localparam logic [3:0] c_TAR2   = 4'd5;
    localparam logic [3:0] c_SYNC   = 4'd6;
    localparam logic [3:0] c_RDATA  = 4'd7;
    localparam logic [3:0] c_TE1    = 4'd8;
    localparam logic [3:0] c_TE2    = 4'd9;

    // Working registers of the cycle in flight
    logic [3:0]    state_q, state_d;
    logic [3:0]    cyc_q, cyc_d;
    logic [31:0]   addr_q, addr_d;
    logic [7:0]    dat_q, dat_d;
    logic [2:0]    nib_q, nib_d;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic          to_en_q, to_en_d;
    logic          serr_q, serr_d;

    // Captured record and pulses
    logic [3:0]    rec_cyc_q, rec_cyc_d;
    logic [31:0]   rec_addr_q, rec_addr_d;
    logic [7:0]    rec_dat_q, rec_dat_d;
    logic          rec_serr_q, rec_serr_d;
    logic          valid_q, valid_d;
    logic          tmo_q, tmo_d;
    logic          abort_q, abort_d;

    logic [CW:0]   w_wnext;
    logic          w_to_en;

    assign w_wnext = {1'b0, wcnt_q} + 1'b1;
    // A long-wait SYNC disables the timeout for the remainder of the cycle
    assign w_to_en = to_en_q & (lpc_ad != 4'b0110);

    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        addr_d     = addr_q;
        dat_d      = dat_q;
        nib_d      = nib_q;
        wcnt_d     = wcnt_q;
        to_en_d    = to_en_q;
        serr_d     = serr_q;
        rec_cyc_d  = rec_cyc_q;
        rec_addr_d = rec_addr_q;
        rec_dat_d  = rec_dat_q;
        rec_serr_d = rec_serr_q;
        valid_d    = 1'b0;
        tmo_d      = 1'b0;
        abort_d    = 1'b0;

        if (!lpc_frame) begin
            // LFRAME# asserted overrides whatever cycle is in progress
            if (lpc_ad == 4'b0000) begin
                state_d = c_CYCDIR;
            end else begin
                abort_d = (lpc_ad == 4'b1111) && (state_q != c_IDLE);
                state_d = c_IDLE;
            end
        end else begin
            case (state_q)
                c_CYCDIR: begin
                    cyc_d   = lpc_ad;
                    addr_d  = '0;
                    dat_d   = '0;
                    serr_d  = 1'b0;
                    to_en_d = 1'b1;
                    wcnt_d  = '0;
                    if (lpc_ad[3:2] == 2'b00 && (!lpc_ad[1] || ENABLE_IO_WRITE)) begin
                        state_d = c_ADDR;
                        nib_d   = 3'd3;
                    end else if (lpc_ad[3:2] == 2'b01 && ENABLE_MEM) begin
                        state_d = c_ADDR;
                        nib_d   = 3'd7;
                    end else begin
                        state_d = c_IDLE;
                    end
                end
                c_ADDR: begin
                    addr_d = {addr_q[27:0], lpc_ad};
                    nib_d  = nib_q - 3'd1;
                    if (nib_q == 3'd0) begin
                        nib_d   = 3'd0;
                        state_d = cyc_q[1] ? c_WDATA : c_TAR1;
                    end
                end
                c_WDATA, c_RDATA: begin
                    // Data byte arrives low nibble first
                    if (!nib_q[0]) begin
                        dat_d[3:0] = lpc_ad;
                        nib_d      = 3'd1;
                    end else begin
                        dat_d[7:4] = lpc_ad;
                        nib_d      = 3'd0;
                        state_d    = (state_q == c_WDATA) ? c_TAR1 : c_TE1;
                    end
                end
                c_TAR1: begin
                    state_d = (lpc_ad == 4'b1111) ? c_TAR2 : c_IDLE;
                end
                c_TAR2: begin
                    state_d = c_SYNC;
                    wcnt_d  = '0;
                end
                c_SYNC: begin
                    case (lpc_ad)
                        4'b0000, 4'b1010: begin
                            serr_d  = (lpc_ad == 4'b1010);
                            nib_d   = 3'd0;
                            state_d = cyc_q[1] ? c_TE1 : c_RDATA;
                        end
                        4'b0101, 4'b0110: begin
                            to_en_d = w_to_en;
                            if (wcnt_q != '1) begin
                                wcnt_d = w_wnext[CW-1:0];
                            end
                            if (w_to_en && (w_wnext >= c_TIMEOUT)) begin
                                tmo_d   = 1'b1;
                                state_d = c_IDLE;
                            end
                        end
                        default: state_d = c_IDLE;
                    endcase
                end
                c_TE1: begin
                    state_d = c_TE2;
                end
                c_TE2: begin
                    state_d    = c_IDLE;
                    rec_cyc_d  = cyc_q;
                    rec_addr_d = addr_q;
                    rec_dat_d  = dat_q;
                    rec_serr_d = serr_q;
                    valid_d    = ((addr_q & ADDR_MASK) == (ADDR_MATCH & ADDR_MASK));
                end
                default: state_d = c_IDLE;
            endcase
        end
    end

    always_ff @(posedge lpc_clock) begin
        if (reset) begin
            state_q    <= c_IDLE;
            cyc_q      <= '0;
            addr_q     <= '0;
            dat_q      <= '0;
            nib_q      <= '0;
            wcnt_q     <= '0;
            to_en_q    <= 1'b0;
            serr_q     <= 1'b0;
            rec_cyc_q  <= '0;
            rec_addr_q <= '0;
            rec_dat_q  <= '0;
            rec_serr_q <= 1'b0;
            valid_q    <= 1'b0;
            tmo_q      <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            addr_q     <= addr_d;
            dat_q      <= dat_d;
            nib_q      <= nib_d;
            wcnt_q     <= wcnt_d;
            to_en_q    <= to_en_d;
            serr_q     <= serr_d;
            rec_cyc_q  <= rec_cyc_d;
            rec_addr_q <= rec_addr_d;
            rec_dat_q  <= rec_dat_d;
            rec_serr_q <= rec_serr_d;
            valid_q    <= valid_d;
            tmo_q      <= tmo_d;
            abort_q    <= abort_d;
        end
    end

    assign out_cyctype_dir  = rec_cyc_q;
    assign out_addr         = rec_addr_q;
    assign out_data         = rec_dat_q;
    assign out_sync_error   = rec_serr_q;
    assign out_valid        = valid_q;
    assign out_sync_timeout = tmo_q;
    assign out_abort        = abort_q;

endmodule
`default_nettype wire
